// File: rtl/controlador_ascensor.sv
// Motion/door controller for the 4-floor car: serves latched requests floor by floor and
// reports the served-request mask so the upstream request register can clear those bits.
module controlador_ascensor #(
  parameter int unsigned T_PISO   = 8,
  parameter int unsigned T_PUERTA = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pedidos,
  input  logic       obstruccion,
  output logic [1:0] piso,
  output logic       motor_subir,
  output logic       motor_bajar,
  output logic       puerta_abierta,
  output logic [9:0] atendidos,
  output logic [1:0] estado
);
  localparam int unsigned T_MAX = (T_PISO > T_PUERTA) ? T_PISO : T_PUERTA;
  localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] CARGA_PISO   = TW'(T_PISO - 1);
  localparam logic [TW-1:0] CARGA_PUERTA = TW'(T_PUERTA - 1);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PUERTA   = 2'd3
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [1:0]    piso_q, piso_d;
  logic          sube_q, sube_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    atendidos_q, atendidos_d;

  function automatic logic [9:0] bits_piso(input logic [1:0] f);
    case (f)
      2'd0:    return 10'b0001000001;
      2'd1:    return 10'b0010000110;
      2'd2:    return 10'b0100011000;
      default: return 10'b1000100000;
    endcase
  endfunction

  function automatic logic [9:0] hall_sube(input logic [1:0] f);
    case (f)
      2'd0:    return 10'h001;
      2'd1:    return 10'h004;
      2'd2:    return 10'h010;
      default: return '0;
    endcase
  endfunction

  function automatic logic [9:0] hall_baja(input logic [1:0] f);
    case (f)
      2'd1:    return 10'h002;
      2'd2:    return 10'h008;
      2'd3:    return 10'h020;
      default: return '0;
    endcase
  endfunction

  function automatic logic [9:0] mas_alla(input logic [1:0] f, input logic sube);
    logic [9:0] m;
    m = '0;
    for (int unsigned g = 0; g < 4; g++)
      if (sube ? (g > 32'(f)) : (g < 32'(f))) m = m | bits_piso(2'(g));
    return m;
  endfunction

  // Returns {last stop in this direction (flip dir), served bits}.
  function automatic logic [10:0] servicio(input logic [1:0] f, input logic sube,
                                           input logic [9:0] ped);
    logic [9:0] m;
    logic       ultimo;
    ultimo = ~|(ped & mas_alla(f, sube));
    m = (10'h040 << f) | (sube ? hall_sube(f) : hall_baja(f));
    if (ultimo) m = m | hall_sube(f) | hall_baja(f);
    return {ultimo, ped & m};
  endfunction

  logic       giro, giro_n, hay_arriba, hay_abajo;
  logic [9:0] mascara, mascara_n;
  logic [1:0] piso_sig;

  always_comb begin
    estado_d    = estado_q;
    piso_d      = piso_q;
    sube_d      = sube_q;
    timer_d     = timer_q;
    atendidos_d = '0;
    {giro, mascara} = servicio(piso_q, sube_q, pedidos);
    piso_sig = (estado_q == SUBIENDO) ? piso_q + 2'd1 : piso_q - 2'd1;
    {giro_n, mascara_n} = servicio(piso_sig, sube_q, pedidos);
    hay_arriba = |(pedidos & mas_alla(piso_q, 1'b1));
    hay_abajo  = |(pedidos & mas_alla(piso_q, 1'b0));
    case (estado_q)
      REPOSO: begin
        if (|(pedidos & bits_piso(piso_q))) begin
          estado_d    = PUERTA;
          timer_d     = CARGA_PUERTA;
          atendidos_d = mascara;
          sube_d      = sube_q ^ giro;
        end else if (hay_arriba && (sube_q || !hay_abajo)) begin
          estado_d = SUBIENDO;
          sube_d   = 1'b1;
          timer_d  = CARGA_PISO;
        end else if (hay_abajo) begin
          estado_d = BAJANDO;
          sube_d   = 1'b0;
          timer_d  = CARGA_PISO;
        end
      end
      SUBIENDO, BAJANDO: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          piso_d = piso_sig;
          if (|mascara_n) begin
            estado_d    = PUERTA;
            timer_d     = CARGA_PUERTA;
            atendidos_d = mascara_n;
            sube_d      = sube_q ^ giro_n;
          end else if (!giro_n) begin
            timer_d = CARGA_PISO;
          end else begin
            estado_d = REPOSO;
          end
        end
      end
      default: begin
        // Bits still in atendidos_q are the stale feedback cycle, not new presses.
        atendidos_d = mascara;
        if (obstruccion || |(mascara & ~atendidos_q)) begin
          timer_d = CARGA_PUERTA;
        end else if (timer_q == '0) begin
          estado_d    = REPOSO;
          atendidos_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= REPOSO;
      piso_q      <= '0;
      sube_q      <= 1'b1;
      timer_q     <= '0;
      atendidos_q <= '0;
    end else begin
      estado_q    <= estado_d;
      piso_q      <= piso_d;
      sube_q      <= sube_d;
      timer_q     <= timer_d;
      atendidos_q <= atendidos_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!((estado_q == SUBIENDO && piso_q == 2'd3) || (estado_q == BAJANDO && piso_q == 2'd0)));
    end
  end

  assign estado         = estado_q;
  assign piso           = piso_q;
  assign motor_subir    = (estado_q == SUBIENDO);
  assign motor_bajar    = (estado_q == BAJANDO);
  assign puerta_abierta = (estado_q == PUERTA);
  assign atendidos      = atendidos_q;
endmodule

// File: tb/tb_controlador_ascensor.sv
// Bench for controlador_ascensor: directed scenarios plus random presses, every cycle checked
// against a floor/request-level reference model fed through an emulated request register.
module tb_controlador_ascensor;
  localparam int TF = 8;
  localparam int TP = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pedidos;
  logic       obstruccion;
  logic [1:0] piso, estado;
  logic       motor_subir, motor_bajar, puerta_abierta;
  logic [9:0] atendidos;

  always #5 clk = ~clk;

  controlador_ascensor #(.T_PISO(TF), .T_PUERTA(TP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pedidos        (pedidos),
    .obstruccion    (obstruccion),
    .piso           (piso),
    .motor_subir    (motor_subir),
    .motor_bajar    (motor_bajar),
    .puerta_abierta (puerta_abierta),
    .atendidos      (atendidos),
    .estado         (estado)
  );

  // Floor of each request bit, and its kind: 0 hall up, 1 hall down, 2 cabin.
  int FLOOR_OF [10] = '{0, 1, 1, 2, 2, 3, 0, 1, 2, 3};
  int KIND     [10] = '{0, 1, 0, 1, 0, 1, 2, 2, 2, 2};

  int         m_st, m_fl, m_t;
  bit         m_up;
  logic [9:0] m_at;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit beyond(int f, bit up, logic [9:0] ped);
    for (int b = 0; b < 10; b++)
      if (ped[b] && (up ? FLOOR_OF[b] > f : FLOOR_OF[b] < f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] svc(int f, bit up, logic [9:0] ped);
    logic [9:0] m;
    bit last;
    m = '0;
    last = !beyond(f, up, ped);
    for (int b = 0; b < 10; b++)
      if (ped[b] && FLOOR_OF[b] == f && (KIND[b] == 2 || KIND[b] == (up ? 0 : 1) || last))
        m[b] = 1'b1;
    return m;
  endfunction

  task automatic open_door();
    m_at = svc(m_fl, m_up, pedidos);
    if (!beyond(m_fl, m_up, pedidos)) m_up = !m_up;
    m_st = 3;
    m_t  = TP - 1;
  endtask

  task automatic model_tick();
    logic [9:0] m;
    bit here;
    if (!rst_n) begin
      m_st = 0; m_fl = 0; m_up = 1'b1; m_t = 0; m_at = '0;
      return;
    end
    case (m_st)
      0: begin
        here = 1'b0;
        for (int b = 0; b < 10; b++) if (pedidos[b] && FLOOR_OF[b] == m_fl) here = 1'b1;
        if (here) open_door();
        else begin
          if (!beyond(m_fl, m_up, pedidos) && beyond(m_fl, !m_up, pedidos)) m_up = !m_up;
          if (beyond(m_fl, m_up, pedidos)) begin
            m_st = m_up ? 1 : 2;
            m_t  = TF - 1;
          end
        end
      end
      1, 2: begin
        if (m_t > 0) m_t--;
        else begin
          m_fl += m_up ? 1 : -1;
          if (svc(m_fl, m_up, pedidos) != '0) open_door();
          else if (beyond(m_fl, m_up, pedidos)) m_t = TF - 1;
          else m_st = 0;
        end
      end
      default: begin
        m = svc(m_fl, m_up, pedidos);
        if (obstruccion || (m & ~m_at) != '0) m_t = TP - 1;
        else if (m_t == 0) begin
          m_st = 0;
          m = '0;
        end else m_t--;
        m_at = m;
      end
    endcase
  endtask

  // One clock: upstream register latches (pedidos | press) & ~atendidos at the edge,
  // so the controller sees cleared bits one cycle after it reports them.
  task automatic step(input logic [9:0] press);
    logic [9:0] nq;
    nq = rst_n ? ((pedidos | press) & ~atendidos) : '0;
    model_tick();
    @(posedge clk);
    #1;
    pedidos = nq;
    chk("outputs",
        {15'd0, estado, piso, motor_subir, motor_bajar, puerta_abierta, atendidos},
        {15'd0, m_st[1:0], m_fl[1:0], m_st == 1, m_st == 2, m_st == 3, m_at});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step('0);
    step('0);
    rst_n = 1'b1;
  endtask

  task automatic wait_st(input logic [1:0] st, input string tag);
    step('0);
    for (int i = 0; i < 200 && estado != st; i++) step('0);
    chk(tag, 32'(estado), 32'(st));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [9:0] press;
    rst_n = 1'b0;
    pedidos = '0;
    obstruccion = 1'b0;
    m_st = 0; m_fl = 0; m_up = 1'b1; m_t = 0; m_at = '0;
    @(posedge clk);
    #1;

    // Idle after reset
    repeat (3) step('0);
    rst_n = 1'b1;
    repeat (20) step('0);
    chk("t1_idle", {15'd0, estado, piso, motor_subir, motor_bajar, puerta_abierta, atendidos}, 32'd0);

    // Cabin P3 from P1: 8 cycles per floor, 5-cycle door
    step(10'h100);
    step('0);
    chk("t2_start", 32'(estado), 32'd1);
    repeat (7) step('0);
    chk("t2_p1_early", 32'(piso), 32'd0);
    step('0);
    chk("t2_p1", 32'(piso), 32'd1);
    repeat (8) step('0);
    chk("t2_p2", 32'(piso), 32'd2);
    chk("t2_door", 32'(estado), 32'd3);
    chk("t2_served", 32'(atendidos), 32'h100);
    n = 0;
    for (int i = 0; i < 30 && puerta_abierta; i++) begin n++; step('0); end
    chk("t2_door_len", 32'(n), 32'd5);
    chk("t2_idle", 32'(estado), 32'd0);

    // P2dn passed on the way up to cabin P4, served on the way down
    do_reset();
    step(10'h202);
    wait_st(2'd3, "t3_first_door");
    chk("t3_first_stop", 32'(piso), 32'd3);
    chk("t3_served_p4", 32'(atendidos), 32'h200);

    // Obstruction held 10 cycles at that door
    n = 0;
    obstruccion = 1'b1;
    for (int i = 0; i < 10; i++) begin n += int'(puerta_abierta); step('0); end
    obstruccion = 1'b0;
    for (int i = 0; i < 30 && puerta_abierta; i++) begin n++; step('0); end
    chk("t4_door_len", 32'(n), 32'd15);

    wait_st(2'd3, "t3_second_door");
    chk("t3_second_stop", 32'(piso), 32'd1);
    chk("t3_served_p2", 32'(atendidos), 32'h002);

    // Idle at P3 with dir up and requests both ways: up first
    do_reset();
    step(10'h300);
    wait_st(2'd3, "t5_door_p3");
    chk("t5_p3", 32'(piso), 32'd2);
    chk("t5_served_p3", 32'(atendidos), 32'h100);
    step(10'h040);
    wait_st(2'd0, "t5_idle");
    step('0);
    chk("t5_up_first", 32'(estado), 32'd1);
    wait_st(2'd3, "t5_door_p4");
    chk("t5_p4", 32'(piso), 32'd3);
    wait_st(2'd0, "t5_idle2");
    wait_st(2'd3, "t5_door_p1");
    chk("t5_p1", 32'(piso), 32'd0);
    chk("t5_served_p1", 32'(atendidos), 32'h040);

    // Reset while descending at P3
    do_reset();
    step(10'h200);
    wait_st(2'd3, "t6_door_p4");
    step(10'h040);
    for (int i = 0; i < 200 && !(estado == 2'd2 && piso == 2'd2); i++) step('0);
    chk("t6_reach", 32'({estado, piso}), 32'h0A);
    rst_n = 1'b0;
    step('0);
    chk("t6_reset", 32'({estado, piso, motor_subir, motor_bajar, puerta_abierta}), 32'd0);
    rst_n = 1'b1;

    // Random presses, obstructions and occasional resets
    for (int i = 0; i < 4000; i++) begin
      obstruccion = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
      press = '0;
      if ($urandom_range(0, 11) == 0) press[$urandom_range(0, 9)] = 1'b1;
      step(press);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
